l1_window_fetch: RTL

//  Layer-1 memory-read stage of the conv engine. Answers the control unit's start_mem_l1 / done_mem_l1 handshake.

---
 rtl/l1_window_fetch_if.sv | 35 +++
 rtl/l1_window_fetch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/l1_window_fetch_if.sv
// Bus bundle for the layer-1 window fetch stage: CU handshake,
// feature-memory read port and the loaded window with its position.
interface l1_window_fetch_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 8
);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic                    start;
    logic                    done;
    logic                    busy;
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_rdata;
    logic [K*K*DATA_W-1:0]   window_flat;
    logic [RW-1:0]           win_row;
    logic [CW-1:0]           win_col;
    logic                    last_win;

    modport master (
        output start, mem_rdata,
        input  done, busy, mem_rd_en, mem_addr,
        input  window_flat, win_row, win_col, last_win
    );

    modport slave (
        input  start, mem_rdata,
        output done, busy, mem_rd_en, mem_addr,
        output window_flat, win_row, win_col, last_win
    );
endinterface

// File: rtl/l1_window_fetch.sv
// Layer-1 memory-read stage: loads one KxK window per CU start into a
// register buffer and steps the window position in raster order.
module l1_window_fetch #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int K         = 3,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input logic clk,
    input logic rst,
    l1_window_fetch_if.slave bus
);
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int KW  = (K > 1) ? $clog2(K) : 1;
    localparam int NW  = K * K;
    localparam int KKW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - K);
    localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - K);
    localparam logic [KW-1:0]  IJ_LAST  = KW'(K - 1);
    localparam logic [KKW-1:0] K_LAST   = KKW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    logic [RW-1:0]        row;
    logic [CW-1:0]        col;
    logic [KW-1:0]        ri, rj;
    logic [KW-1:0]        ni, nj;
    logic [KKW-1:0]       k;
    logic [KKW-1:0]       cap_k;
    logic                 cap_v;
    logic                 done_q;
    logic                 busy_q;
    logic                 rd_en_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [NW*DATA_W-1:0] win_q;

    function automatic logic [ADDR_W-1:0] rd_addr(
        input logic [KW-1:0] i,
        input logic [KW-1:0] j
    );
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] c;
        r = ADDR_W'(row) + ADDR_W'(i);
        c = ADDR_W'(col) + ADDR_W'(j);
        return ADDR_W'(BASE_ADDR) + r * ADDR_W'(IMG_W) + c;
    endfunction

    // Next (i,j) inside the window, row-major
    always_comb begin
        ni = ri;
        nj = rj + 1'b1;
        if (rj == IJ_LAST) begin
            ni = ri + 1'b1;
            nj = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            ri      <= '0;
            rj      <= '0;
            k       <= '0;
            cap_k   <= '0;
            cap_v   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            win_q   <= '0;
        end else begin
            // Read data arrives one cycle after the strobe
            cap_v <= rd_en_q;
            cap_k <= k;
            if (cap_v)
                win_q[int'(cap_k)*DATA_W +: DATA_W] <= bus.mem_rdata;

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= FETCH;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        ri      <= '0;
                        rj      <= '0;
                        k       <= '0;
                        addr_q  <= rd_addr('0, '0);
                    end
                end
                FETCH: begin
                    if (k == K_LAST) begin
                        state   <= DRAIN;
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        k      <= k + 1'b1;
                        ri     <= ni;
                        rj     <= nj;
                        addr_q <= rd_addr(ni, nj);
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                DONE: begin
                    if (!bus.start) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.window_flat = win_q;
    assign bus.win_row     = row;
    assign bus.win_col     = col;
    assign bus.last_win    = (row == ROW_LAST) && (col == COL_LAST);
endmodule
